// File: rtl/fila_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fila_pkg
// Description : Shared types and helpers for the parametrised queue.
//               - fila_mode_t : ordering discipline (FIFO / LIFO)
//               - fila_len_w  : width of an element count for a given depth
//                               (one bit wider than a pointer so that the
//                               value DEPTH itself is representable)
// Revision    : 1.0 - initial release
// ============================================================================
package fila_pkg;

    typedef enum logic {
        FILA_FIFO = 1'b0,
        FILA_LIFO = 1'b1
    } fila_mode_t;

    function automatic int fila_len_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fila_param_rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : Single-bit rising-edge detector. pulse_out is high during the
//               one cycle in which level_in is high and was low at the
//               previous clock edge. The history register resets to 0, so a
//               level already high when reset releases is seen as an edge.
// Ports       : clock_10KHz - system clock
//               reset       - asynchronous, active-high
//               level_in    - request level
//               pulse_out   - one-cycle event (combinational from register)
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clock_10KHz,
    input  logic reset,
    input  logic level_in,
    output logic pulse_out
);

    logic r_level_q;

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= level_in;
        end
    end

    assign pulse_out = level_in & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/fila_param.sv
`default_nettype none
// ============================================================================
// Module      : fila_param
// Description : Parametrised queue with FIFO or LIFO ordering. Enqueue and
//               dequeue act on rising edges of their request lines; clear is
//               a level-sensitive synchronous flush with top priority.
// Ports       : clock_10KHz   - system clock, all state on its rising edge
//               reset         - asynchronous, active-high
//               data_in       - element written on an enqueue event
//               enqueue_in    - enqueue request (rising edge)
//               dequeue_in    - dequeue request (rising edge)
//               clear_in      - synchronous flush
//               data_out      - last element removed (registered)
//               len_out       - element count, 0..DEPTH
//               full_out      - len_out == DEPTH
//               empty_out     - len_out == 0
//               overflow_out  - pulse: enqueue rejected while full
//               underflow_out - pulse: dequeue while empty
// Revision    : 1.0 - initial release
// ============================================================================
module fila_param
    import fila_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int LIFO_MODE = 0
) (
    input  logic                          clock_10KHz,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          enqueue_in,
    input  logic                          dequeue_in,
    input  logic                          clear_in,
    output logic [DATA_W-1:0]             data_out,
    output logic [fila_len_w(DEPTH)-1:0]  len_out,
    output logic                          full_out,
    output logic                          empty_out,
    output logic                          overflow_out,
    output logic                          underflow_out
);

    localparam int                  c_PTR_W    = $clog2(DEPTH);
    localparam int                  c_LEN_W    = fila_len_w(DEPTH);
    localparam fila_mode_t          c_MODE     = (LIFO_MODE != 0) ? FILA_LIFO : FILA_FIFO;
    localparam logic [c_LEN_W-1:0]  c_LEN_ONE  = c_LEN_W'(1);
    localparam logic [c_LEN_W-1:0]  c_LEN_FULL = c_LEN_W'(DEPTH);

    logic                w_enq_ev;
    logic                w_deq_ev;
    logic                w_empty;
    logic                w_full;
    logic                w_enq_ok;
    logic                w_deq_ok;
    logic                w_overflow;
    logic                w_underflow;
    logic [c_PTR_W-1:0]  w_wr_addr;
    logic [c_PTR_W-1:0]  w_rd_addr;

    logic [c_LEN_W-1:0]  r_len;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_overflow;
    logic                r_underflow;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    rise_detect u_enq_edge (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .level_in    (enqueue_in),
        .pulse_out   (w_enq_ev)
    );

    rise_detect u_deq_edge (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .level_in    (dequeue_in),
        .pulse_out   (w_deq_ev)
    );

    assign w_empty = (r_len == '0);
    assign w_full  = (r_len == c_LEN_FULL);

    // A full queue still accepts a write when a read happens on the same
    // edge (FIFO read-and-write or LIFO swap), so no overflow in that case.
    // An empty queue always accepts the write; the paired read underflows.
    assign w_enq_ok    = w_enq_ev & ~clear_in & (~w_full | w_deq_ev);
    assign w_deq_ok    = w_deq_ev & ~clear_in & ~w_empty;
    assign w_overflow  = w_enq_ev & ~clear_in & w_full & ~w_deq_ev;
    assign w_underflow = w_deq_ev & ~clear_in & w_empty;

    generate
        if (c_MODE == FILA_FIFO) begin : g_fifo
            logic [c_PTR_W-1:0] r_head;
            logic [c_PTR_W-1:0] r_tail;

            // Pointers are exactly log2(DEPTH) bits and wrap on overflow.
            always_ff @(posedge clock_10KHz or posedge reset) begin
                if (reset) begin
                    r_head <= '0;
                    r_tail <= '0;
                end else if (clear_in) begin
                    r_head <= '0;
                    r_tail <= '0;
                end else begin
                    if (w_enq_ok) begin
                        r_tail <= r_tail + c_PTR_W'(1);
                    end
                    if (w_deq_ok) begin
                        r_head <= r_head + c_PTR_W'(1);
                    end
                end
            end

            assign w_wr_addr = r_tail;
            assign w_rd_addr = r_head;
        end else begin : g_lifo
            // Stack pointer is the count itself. Only the low bits address
            // storage: at len == DEPTH they are 0 and the top is DEPTH-1.
            assign w_rd_addr = r_len[c_PTR_W-1:0] - c_PTR_W'(1);
            // On a swap the new element overwrites the current top.
            assign w_wr_addr = w_deq_ok ? w_rd_addr : r_len[c_PTR_W-1:0];
        end
    endgenerate

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock_10KHz) begin
        if (w_enq_ok) begin
            r_mem[w_wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            r_len       <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_overflow;
            r_underflow <= w_underflow;

            if (clear_in) begin
                r_len <= '0;
            end else if (w_enq_ok && !w_deq_ok) begin
                r_len <= r_len + c_LEN_ONE;
            end else if (!w_enq_ok && w_deq_ok) begin
                r_len <= r_len - c_LEN_ONE;
            end

            // data_out is held across a flush.
            if (w_underflow) begin
                r_data_out <= '0;
            end else if (w_deq_ok) begin
                r_data_out <= r_mem[w_rd_addr];
            end
        end
    end

    assign data_out      = r_data_out;
    assign len_out       = r_len;
    assign full_out      = w_full;
    assign empty_out     = w_empty;
    assign overflow_out  = r_overflow;
    assign underflow_out = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fila_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fila_param
// Description : Bench for fila_param. Three instances share one stimulus:
//               A = FIFO 8x8, B = LIFO 8x8, C = FIFO 16-bit x 4. A queue-based
//               reference model tracks all three every cycle; a vector table
//               and hand-written sequences hold fixed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fila_param;

    logic        clock_10KHz = 1'b0;
    logic        reset;
    logic        enq = 1'b0;
    logic        deq = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] din = '0;

    logic [7:0]  dout_a, dout_b;
    logic [15:0] dout_c;
    logic [3:0]  len_a, len_b;
    logic [2:0]  len_c;
    logic        full_a, full_b, full_c;
    logic        empty_a, empty_b, empty_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        unf_a, unf_b, unf_c;

    int total = 0;
    int bad   = 0;

    always #5 clock_10KHz = ~clock_10KHz;

    fila_param #(.DATA_W(8), .DEPTH(8), .LIFO_MODE(0)) u_a (
        .clock_10KHz(clock_10KHz), .reset(reset), .data_in(din[7:0]),
        .enqueue_in(enq), .dequeue_in(deq), .clear_in(clr),
        .data_out(dout_a), .len_out(len_a), .full_out(full_a),
        .empty_out(empty_a), .overflow_out(ovf_a), .underflow_out(unf_a));

    fila_param #(.DATA_W(8), .DEPTH(8), .LIFO_MODE(1)) u_b (
        .clock_10KHz(clock_10KHz), .reset(reset), .data_in(din[7:0]),
        .enqueue_in(enq), .dequeue_in(deq), .clear_in(clr),
        .data_out(dout_b), .len_out(len_b), .full_out(full_b),
        .empty_out(empty_b), .overflow_out(ovf_b), .underflow_out(unf_b));

    fila_param #(.DATA_W(16), .DEPTH(4), .LIFO_MODE(0)) u_c (
        .clock_10KHz(clock_10KHz), .reset(reset), .data_in(din),
        .enqueue_in(enq), .dequeue_in(deq), .clear_in(clr),
        .data_out(dout_c), .len_out(len_c), .full_out(full_c),
        .empty_out(empty_c), .overflow_out(ovf_c), .underflow_out(unf_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] d_dout [3];
    logic [3:0]  d_len  [3];
    logic        d_full [3], d_empty [3], d_ovf [3], d_unf [3];

    assign d_dout[0] = {8'h00, dout_a};
    assign d_dout[1] = {8'h00, dout_b};
    assign d_dout[2] = dout_c;
    assign d_len[0]  = len_a;
    assign d_len[1]  = len_b;
    assign d_len[2]  = {1'b0, len_c};
    assign d_full[0] = full_a;  assign d_full[1] = full_b;  assign d_full[2] = full_c;
    assign d_empty[0] = empty_a; assign d_empty[1] = empty_b; assign d_empty[2] = empty_c;
    assign d_ovf[0] = ovf_a; assign d_ovf[1] = ovf_b; assign d_ovf[2] = ovf_c;
    assign d_unf[0] = unf_a; assign d_unf[1] = unf_b; assign d_unf[2] = unf_c;

    int          depth_k [3] = '{8, 8, 4};
    bit          lifo_k  [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] mask_k  [3] = '{16'h00ff, 16'h00ff, 16'hffff};

    logic [15:0] mq [3][$];
    logic [15:0] m_dout [3];
    bit          m_ovf [3], m_unf [3];
    bit          m_pe, m_pd;

    // Inputs as seen by the DUTs at the last rising edge.
    bit          s_valid = 1'b0;
    bit          s_enq, s_deq, s_clr;
    logic [15:0] s_din;

    always @(posedge clock_10KHz) begin
        s_valid <= !reset;
        s_enq   <= enq;
        s_deq   <= deq;
        s_clr   <= clr;
        s_din   <= din;
    end

    task automatic model_reset();
        m_pe = 1'b0;
        m_pd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_dout[k] = '0;
            m_ovf[k]  = 1'b0;
            m_unf[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        bit ee, de;
        ee   = s_enq && !m_pe;
        de   = s_deq && !m_pd;
        m_pe = s_enq;
        m_pd = s_deq;
        for (int k = 0; k < 3; k++) begin
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
            if (s_clr) begin
                mq[k].delete();
            end else if (mq[k].size() == 0) begin
                if (de) begin
                    m_unf[k]  = 1'b1;
                    m_dout[k] = '0;
                end
                if (ee) mq[k].push_back(s_din & mask_k[k]);
            end else begin
                if (de) begin
                    if (lifo_k[k]) m_dout[k] = mq[k].pop_back();
                    else           m_dout[k] = mq[k].pop_front();
                end
                if (ee) begin
                    if (!de && mq[k].size() == depth_k[k]) m_ovf[k] = 1'b1;
                    else                                   mq[k].push_back(s_din & mask_k[k]);
                end
            end
        end
    endtask

    always @(negedge clock_10KHz) begin
        if (reset) begin
            model_reset();
        end else if (s_valid) begin
            model_step();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("mdl%0d_dout", k),  d_dout[k],  m_dout[k]);
                chk($sformatf("mdl%0d_len", k),   d_len[k],   mq[k].size());
                chk($sformatf("mdl%0d_full", k),  d_full[k],  mq[k].size() == depth_k[k]);
                chk($sformatf("mdl%0d_empty", k), d_empty[k], mq[k].size() == 0);
                chk($sformatf("mdl%0d_ovf", k),   d_ovf[k],   m_ovf[k]);
                chk($sformatf("mdl%0d_unf", k),   d_unf[k],   m_unf[k]);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit          enq;
        bit          deq;
        logic [15:0] d;
        int          cyc;
        int          len_a;
        logic [7:0]  dout_a;
        int          len_b;
        logic [7:0]  dout_b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit e, input bit q, input logic [15:0] d, input int cyc,
                       input int la, input logic [7:0] da, input int lb, input logic [7:0] db);
        vec_t v;
        v.enq = e; v.deq = q; v.d = d; v.cyc = cyc;
        v.len_a = la; v.dout_a = da; v.len_b = lb; v.dout_b = db;
        tbl.push_back(v);
    endtask

    task automatic pulse_enq(input logic [15:0] d);
        @(negedge clock_10KHz); enq = 1'b1; din = d;
        @(negedge clock_10KHz); enq = 1'b0;
    endtask

    task automatic pulse_deq();
        @(negedge clock_10KHz); deq = 1'b1;
        @(negedge clock_10KHz); deq = 1'b0;
    endtask

    logic [15:0] c_vals [4] = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'hA5C3};

    initial begin
        reset = 1'b1;

        // rows: enq, deq, data, cycles held, then expected A len/dout, B len/dout
        add(1, 0, 16'h11, 5, 1, 8'h00, 1, 8'h00);
        add(1, 0, 16'h22, 5, 2, 8'h00, 2, 8'h00);
        add(1, 0, 16'h33, 5, 3, 8'h00, 3, 8'h00);
        add(0, 1, 16'h00, 5, 2, 8'h11, 2, 8'h33);
        add(0, 1, 16'h00, 1, 1, 8'h22, 1, 8'h22);
        add(0, 1, 16'h00, 1, 0, 8'h33, 0, 8'h11);
        add(0, 1, 16'h00, 1, 0, 8'h00, 0, 8'h00);
        add(1, 1, 16'h5A, 1, 1, 8'h00, 1, 8'h00);
        add(0, 1, 16'h00, 1, 0, 8'h5A, 0, 8'h5A);
        add(1, 0, 16'h01, 1, 1, 8'h5A, 1, 8'h5A);
        add(1, 0, 16'h02, 1, 2, 8'h5A, 2, 8'h5A);
        add(1, 0, 16'h03, 1, 3, 8'h5A, 3, 8'h5A);
        add(0, 1, 16'h00, 1, 2, 8'h01, 2, 8'h03);
        add(1, 1, 16'h04, 1, 2, 8'h02, 2, 8'h02);
        add(0, 1, 16'h00, 1, 1, 8'h03, 1, 8'h04);
        add(0, 1, 16'h00, 1, 0, 8'h04, 0, 8'h01);
        for (int i = 0; i < 8; i++) add(1, 0, 16'(8'h80 + i), 1, i + 1, 8'h04, i + 1, 8'h01);
        add(1, 0, 16'h99, 1, 8, 8'h04, 8, 8'h01);
        for (int i = 0; i < 12; i++)
            add(1, 1, 16'(8'hA0 + i), 1,
                8, (i < 8) ? 8'(8'h80 + i) : 8'(8'hA0 + i - 8),
                8, (i == 0) ? 8'h87 : 8'(8'hA0 + i - 1));
        for (int i = 0; i < 8; i++)
            add(0, 1, 16'h00, 1, 7 - i, 8'(8'hA4 + i),
                7 - i, (i == 0) ? 8'hAB : 8'(8'h87 - i));

        // reset state
        repeat (2) @(negedge clock_10KHz);
        chk("rst_len_a", len_a, 0);
        chk("rst_dout_a", dout_a, 0);
        chk("rst_empty_a", empty_a, 1);
        chk("rst_full_a", full_a, 0);
        chk("rst_pulses", {ovf_a, unf_a, ovf_b, unf_b}, 0);
        chk("rst_len_c", len_c, 0);
        reset = 1'b0;

        foreach (tbl[r]) begin
            @(negedge clock_10KHz);
            enq = tbl[r].enq; deq = tbl[r].deq; din = tbl[r].d;
            repeat (tbl[r].cyc) @(negedge clock_10KHz);
            enq = 1'b0; deq = 1'b0;
            @(negedge clock_10KHz);
            chk($sformatf("tbl%0d_len_a", r), len_a, tbl[r].len_a);
            chk($sformatf("tbl%0d_dout_a", r), dout_a, tbl[r].dout_a);
            chk($sformatf("tbl%0d_len_b", r), len_b, tbl[r].len_b);
            chk($sformatf("tbl%0d_dout_b", r), dout_b, tbl[r].dout_b);
        end

        // overflow pulse lasts one cycle; held request does not retrigger
        for (int i = 0; i < 8; i++) pulse_enq(16'(8'h40 + i));
        @(negedge clock_10KHz); enq = 1'b1; din = 16'h99;
        @(negedge clock_10KHz);
        chk("ovf_a_pulse", ovf_a, 1);
        chk("ovf_b_pulse", ovf_b, 1);
        chk("ovf_len_a", len_a, 8);
        chk("ovf_full_a", full_a, 1);
        @(negedge clock_10KHz);
        chk("ovf_a_drop", ovf_a, 0);
        enq = 1'b0;

        // flush with a coincident enqueue edge, request held across it
        @(negedge clock_10KHz); clr = 1'b1; enq = 1'b1; din = 16'h77;
        @(negedge clock_10KHz);
        chk("clr_len_a", len_a, 0);
        chk("clr_empty_a", empty_a, 1);
        chk("clr_dout_a_held", dout_a, 8'hAB);
        chk("clr_dout_b_held", dout_b, 8'h80);
        clr = 1'b0;
        @(negedge clock_10KHz);
        chk("clr_no_retrig_a", len_a, 0);
        chk("clr_no_retrig_b", len_b, 0);
        enq = 1'b0;

        // underflow
        @(negedge clock_10KHz); deq = 1'b1;
        @(negedge clock_10KHz);
        chk("unf_a_pulse", unf_a, 1);
        chk("unf_dout_a", dout_a, 0);
        chk("unf_len_a", len_a, 0);
        @(negedge clock_10KHz);
        chk("unf_a_drop", unf_a, 0);
        deq = 1'b0;

        // asynchronous reset mid-cycle, request held through reset release
        pulse_enq(16'h31); pulse_enq(16'h32); pulse_enq(16'h33);
        pulse_deq();
        chk("pre_rst_dout_a", dout_a, 8'h31);
        @(negedge clock_10KHz); enq = 1'b1; din = 16'h55;
        #2 reset = 1'b1;
        #1;
        chk("arst_len_a", len_a, 0);
        chk("arst_dout_a", dout_a, 0);
        chk("arst_empty_a", empty_a, 1);
        chk("arst_dout_b", dout_b, 0);
        @(negedge clock_10KHz);
        @(negedge clock_10KHz); reset = 1'b0;
        @(negedge clock_10KHz);
        chk("post_rst_edge_a", len_a, 1);
        enq = 1'b0;
        pulse_deq();

        // 16-bit x 4 instance: fill, full flag, drain in order
        for (int i = 0; i < 4; i++) pulse_enq(c_vals[i]);
        chk("c_full", full_c, 1);
        chk("c_len", len_c, 3'b100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_10KHz); deq = 1'b1;
            @(negedge clock_10KHz);
            chk($sformatf("c_drain%0d", i), dout_c, c_vals[i]);
            deq = 1'b0;
        end

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock_10KHz);
            enq = 1'($urandom_range(0, 1));
            deq = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 39) == 0);
            din = 16'($urandom);
        end
        @(negedge clock_10KHz);
        enq = 1'b0; deq = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clock_10KHz);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fila_param.md
Name: fila_param

Overview:
- Parametrised successor of the 8x8 queue: configurable data width and depth, with FIFO or LIFO ordering selected by parameter.
- Each operation is triggered by a rising edge of its request line, so a level held for many clock_10KHz cycles performs one operation.
- Adds full/empty flags, overflow/underflow pulses, a synchronous flush, and defined simultaneous enqueue+dequeue.
- Sits between the input producer (keypad/serial side) and the consumer logic, in the same 10 kHz clock domain.

Parameters:
DATA_W, 8, width of each stored element and of data_in/data_out
DEPTH, 8, number of entries; power of two, at least 2
LIFO_MODE, 0, 0 = FIFO (oldest out first), 1 = LIFO (newest out first)

Ports:
clock_10KHz  input  1  single system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
data_in  input  DATA_W  element to store on an enqueue event
enqueue_in  input  1  enqueue request; acts on its rising edge only
dequeue_in  input  1  dequeue request; acts on its rising edge only
clear_in  input  1  synchronous flush, level-sensitive, highest priority
data_out  output  DATA_W  last element removed; registered
len_out  output  $clog2(DEPTH)+1  current element count, 0..DEPTH
full_out  output  1  high when len_out == DEPTH
empty_out  output  1  high when len_out == 0
overflow_out  output  1  one-cycle pulse: enqueue event rejected because the queue was full
underflow_out  output  1  one-cycle pulse: dequeue event on an empty queue

Behaviour:
- Reset (async, active-high): pointers 0, len_out 0, data_out 0, overflow_out 0, underflow_out 0, edge-detect history 0, empty_out 1, full_out 0. Storage array is not cleared.
- Edge detection:
  - enq_ev = enqueue_in & ~enq_q and deq_ev = dequeue_in & ~deq_q, where enq_q/deq_q hold the previous-cycle samples.
  - A level held high gives exactly one event.
  - A request already high when reset deasserts counts as an edge on the first clock.
- Latency:
  - An event sampled at edge N updates storage, len_out and flags at edge N.
  - On a dequeue, data_out shows the removed element from edge N, i.e. it is valid in cycle N+1.
- FIFO mode (LIFO_MODE=0):
  - Write at tail_ptr, read at head_ptr.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- LIFO mode (LIFO_MODE=1):
  - Single stack pointer sp = len_out.
  - Push writes at sp; pop reads at sp-1.
- Enqueue event while full: no write, pointers and len unchanged, overflow_out = 1 for one cycle.
- Dequeue event while empty: data_out <= 0, len unchanged, underflow_out = 1 for one cycle.
- Simultaneous enq_ev and deq_ev, judged on pre-edge state:
  - Empty: enqueue succeeds, dequeue underflows (data_out 0, underflow pulse), len becomes 1.
  - FIFO, non-empty (full included): read head and write tail in the same edge; data_out gets the old head value; len unchanged; both pointers advance.
  - LIFO, non-empty: swap; data_out gets the old top; data_in replaces the top; len unchanged.
  - No overflow is flagged in either non-empty case.
- clear_in high at an edge: pointers and len_out go to 0, pending events are discarded, data_out is held, pulses are 0. Edge history still updates, so a request held across the clear does not retrigger.
- Reset mid-operation: an in-flight event is lost, and all outputs return to their reset values asynchronously.
- Arithmetic: len_out is one bit wider than a pointer, so DEPTH is representable. full_out and empty_out are decoded from len_out and are glitch-free because they are decoded from a register.
- State: no multi-cycle FSM. Each operation completes in a single cycle. The only state is the edge-detect history, the pointers, len and the storage.

Decomposition:
- Package fila_pkg: typedef enum logic {FILA_FIFO, FILA_LIFO} fila_mode_t; function clog2-based width helper for len.
- Sub-module rise_detect (1-bit: clock_10KHz, reset, level_in, pulse_out), instantiated twice (enqueue_in, dequeue_in).
- Storage array and pointer logic stay inline in fila_param.

Test Plan:
- FIFO, DATA_W=8, DEPTH=8:
  - Enqueue 0x11, 0x22, 0x33 (each request held 5 cycles), then 3 dequeues -> data_out 0x11, 0x22, 0x33 in order; len_out 3->0; empty_out 1 at the end.
  - Fill 8 entries, enqueue 0x99 -> overflow_out pulses 1 cycle; len_out stays 8, full_out 1. Then 12 enqueue/dequeue pairs -> pointers wrap and order is preserved.
  - Empty queue, dequeue -> data_out 0x00, underflow_out 1 cycle, len_out 0. Then simultaneous enq(0x5A)+deq -> len_out 1, underflow pulse; next dequeue returns 0x5A.
- LIFO_MODE=1:
  - Push 0x01, 0x02, 0x03; pop -> 0x03. Simultaneous push 0x04 + pop -> data_out 0x02, len 2. Next pop -> 0x04.
- Flush and reset:
  - Fill 5 entries, assert clear_in with enqueue_in held high -> len_out 0, no write; after clear_in drops, no spurious enqueue.
  - Assert reset asynchronously mid-sequence -> len_out 0, data_out 0, empty_out 1 before the next clock edge.
- DATA_W=16, DEPTH=4: fill 4 -> full_out 1, len_out 3'b100. Drain -> values returned in order.
